cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file for the 5-stage MIPS pipeline, sitting at the MEM stage.
- Consumes the merged exception cause word produced by the MEM-stage exception control logic, plus raw hardware interrupt lines.
- Decides whether to take an exception or interrupt, and holds SR, Cause, EPC and PRId.
- Provides the redirect request and EPC to the fetch logic, and services mfc0/mtc0/eret.

Parameters:
- PRID_VALUE, 32'h2017_1226, constant returned on reads of register 15.
- EPC_RESET, 32'h0000_3000, EPC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- a1  input  5  mfc0 read register index.
- a2  input  5  mtc0 write register index.
- din  input  32  mtc0 write data.
- we  input  1  mtc0 write enable.
- pc  input  32  PC of the instruction currently in MEM.
- causein  input  32  merged cause from MEM exception control; [31]=BD, [6:2]=ExcCode (0 = none).
- hwint  input  6  raw device interrupt lines, level sensitive.
- eret  input  1  eret in MEM.
- intreq  output  1  take exception/interrupt this cycle; flush pipeline, redirect PC to handler.
- epc  output  32  current EPC register, used as eret target.
- dout  output  32  mfc0 read data.

Behaviour:
- Registers:
  - SR(12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - EPC(14): 32 bits, bits [1:0] always 0.
  - PRId(15): constant PRID_VALUE.
- Reset (reset=0, asynchronous): IM=6'b111111, EXL=0, IE=1, BD=0, IP=0, ExcCode=0, EPC=EPC_RESET. Outputs after reset: intreq=0 (for hwint=0, causein=0), epc=EPC_RESET.
- Request logic (combinational, same cycle):
  - irq = IE & ~EXL & |(hwint & IM).
  - exc = ~EXL & (causein[6:2] != 0).
  - intreq = irq | exc.
  - Interrupt has priority over synchronous exceptions.
- Taking a request, on a rising edge with intreq=1:
  - EXL<=1.
  - ExcCode<= 0 if irq, else causein[6:2].
  - BD<=causein[31].
  - EPC<= BD ? {pc[31:2],2'b00}-4 : {pc[31:2],2'b00}.
- IP update: IP<=hwint on every rising edge, independent of EXL/IE, so software always sees live lines.
- eret: on a rising edge with eret=1 and intreq=0, EXL<=0. No other field changes.
- mtc0: on a rising edge with we=1 and intreq=0:
  - a2=12 writes IM, EXL and IE from din[15:10], din[1], din[0].
  - a2=14 writes EPC<={din[31:2],2'b00}.
  - Writes to 13, 15 or any other index are ignored.
- Priority on the same edge: intreq > eret > mtc0. A pending mtc0 or eret in the faulting slot is discarded when intreq=1.
- Nested events: while EXL=1, intreq is held 0 regardless of hwint or causein (no nesting); ExcCode and EPC are frozen except via mtc0 to EPC.
- Read path:
  - dout is combinational from current register state by a1: 12/13/14/15 as above, all other indices return 0.
  - No internal write-to-read bypass; a same-cycle mtc0 is visible on the next cycle.
- epc output is the registered EPC, with no bypass of a same-cycle write.
- Reset mid-operation (e.g. EXL=1, handler running): all fields return to reset values immediately, without waiting for a clock edge.
- Latency: intreq is 0-cycle combinational; state updates are 1 cycle.

Test Plan:
- Reset → release reset, read a1=12 → dout=32'h0000_FC01; a1=15 → PRID_VALUE; epc=32'h0000_3000; intreq=0.
- Interrupt → hwint=6'b000100, pc=32'h0000_3010, causein=0 → intreq=1 same cycle. After the edge: EXL=1, Cause=32'h0000_1000, epc=32'h0000_3010. Next cycle intreq=0 with hwint still high.
- Exception in delay slot → causein={1'b1,24'b0,5'd4,2'b0}, pc=32'h0000_3024 → intreq=1. After the edge: Cause=32'h8000_0010, epc=32'h0000_3020.
- Priority → hwint=6'b000001 and causein ExcCode=5 in the same cycle → after the edge ExcCode=0 and IP[10]=1. Repeat with IE=0 (via mtc0 SR=32'h0000_FC00) → ExcCode=5.
- eret/mtc0 → with EXL=1:
  - mtc0 a2=14 din=32'h0000_3047 → epc=32'h0000_3044.
  - eret → EXL=0; pending hwint immediately raises intreq.
  - mtc0 a2=13 → Cause unchanged.
- Reset mid-handler → EXL=1, ExcCode=12; assert reset between clock edges → SR=32'h0000_FC01, Cause=0 immediately.

Source files
------------

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file at the MEM stage: decides exception/interrupt
// entry, holds SR/Cause/EPC/PRId and services mfc0, mtc0 and eret.
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE = 32'h2017_1226,
  parameter logic [31:0] EPC_RESET  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic [31:0] causein,
  input  logic [5:0]  hwint,
  input  logic        eret,
  output logic        intreq,
  output logic [31:0] epc,
  output logic [31:0] dout
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:2] epc_q, epc_d;

  logic        irq;
  logic        exc;
  logic [31:2] epc_take;
  logic [31:0] sr_w;
  logic [31:0] cause_w;
  logic        unused_bits;

  assign unused_bits = ^{causein[30:7], causein[1:0], pc[1:0]};

  // Interrupts win over synchronous exceptions; EXL blocks any nesting.
  assign irq      = ie_q & ~exl_q & (|(hwint & im_q));
  assign exc      = ~exl_q & (causein[6:2] != 5'd0);
  assign intreq   = irq | exc;
  assign epc_take = causein[31] ? (pc[31:2] - 30'd1) : pc[31:2];

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hwint;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (intreq) begin
      exl_d      = 1'b1;
      exc_code_d = irq ? 5'd0 : causein[6:2];
      bd_d       = causein[31];
      epc_d      = epc_take;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (we) begin
      case (a2)
        REG_SR: begin
          im_d  = din[15:10];
          exl_d = din[1];
          ie_d  = din[0];
        end
        REG_EPC: epc_d = din[31:2];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= 6'b111111;
      exl_q      <= 1'b0;
      ie_q       <= 1'b1;
      bd_q       <= 1'b0;
      ip_q       <= 6'b0;
      exc_code_q <= 5'd0;
      epc_q      <= EPC_RESET[31:2];
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  assign sr_w    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_w = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
  assign epc     = {epc_q, 2'b00};

  always_comb begin
    case (a1)
      REG_SR:    dout = sr_w;
      REG_CAUSE: dout = cause_w;
      REG_EPC:   dout = {epc_q, 2'b00};
      REG_PRID:  dout = PRID_VALUE;
      default:   dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed vector bench for cp0_regfile: one table row per clock cycle, outputs
// checked before the edge that commits the row, plus an asynchronous reset check.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  a1 = 5'd0;
  logic [4:0]  a2 = 5'd0;
  logic [31:0] din = 32'd0;
  logic        we = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] causein = 32'd0;
  logic [5:0]  hwint = 6'd0;
  logic        eret = 1'b0;
  logic        intreq;
  logic [31:0] epc;
  logic [31:0] dout;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic [31:0] causein;
    logic [5:0]  hwint;
    logic        eret;
    logic        exp_intreq;
    logic [31:0] exp_epc;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  cp0_regfile dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din), .we(we), .pc(pc),
    .causein(causein), .hwint(hwint), .eret(eret),
    .intreq(intreq), .epc(epc), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [4:0] va1, input logic [4:0] va2, input logic [31:0] vdin,
                     input logic vwe, input logic [31:0] vpc, input logic [31:0] vcause,
                     input logic [5:0] vhw, input logic veret, input logic xint,
                     input logic [31:0] xepc, input logic [31:0] xdout);
    vec_t v;
    v.a1 = va1; v.a2 = va2; v.din = vdin; v.we = vwe; v.pc = vpc; v.causein = vcause;
    v.hwint = vhw; v.eret = veret; v.exp_intreq = xint; v.exp_epc = xepc; v.exp_dout = xdout;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // a1, a2, din, we, pc, causein, hwint, eret | intreq, epc, dout
    add(12, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h3000, 32'h0000_FC01);
    add(15, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h3000, 32'h2017_1226);
    add(13, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h3000, 32'h0);
    add(14, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h3000, 32'h3000);
    add(5,  0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h3000, 32'h0);
    // interrupt on hwint[2]
    add(12, 0, 0, 0, 32'h3010, 0, 6'b000100, 0, 1, 32'h3000, 32'h0000_FC01);
    add(13, 0, 0, 0, 0, 0, 6'b000100, 0, 0, 32'h3010, 32'h0000_1000);
    add(12, 0, 0, 0, 0, 0, 6'b000100, 0, 0, 32'h3010, 32'h0000_FC03);
    add(12, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 32'h3010, 32'h0000_FC03);
    // exception in a delay slot
    add(13, 0, 0, 0, 32'h3024, 32'h8000_0010, 6'b000000, 0, 1, 32'h3010, 32'h0);
    add(13, 0, 0, 0, 32'h3030, 32'h0000_0010, 6'b000000, 0, 0, 32'h3020, 32'h8000_0010);
    // mtc0 EPC while EXL=1, then an ignored write to Cause
    add(14, 14, 32'h3047, 1, 0, 0, 6'b000000, 0, 0, 32'h3020, 32'h3020);
    add(14, 13, 32'hFFFF_FFFF, 1, 0, 0, 6'b000000, 0, 0, 32'h3044, 32'h3044);
    add(13, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 32'h3044, 32'h8000_0010);
    add(13, 0, 0, 0, 0, 0, 6'b000001, 1, 0, 32'h3044, 32'h8000_0410);
    // pending interrupt fires after eret and beats a same-cycle exception
    add(12, 0, 0, 0, 32'h3100, 32'h0000_0014, 6'b000001, 0, 1, 32'h3044, 32'h0000_FC01);
    add(13, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h3100, 32'h0000_0400);
    // SR write with IE=0, then the exception wins
    add(12, 12, 32'h0000_FC00, 1, 0, 0, 6'b000000, 0, 0, 32'h3100, 32'h0000_FC03);
    add(12, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 32'h3100, 32'h0000_FC00);
    add(13, 0, 0, 0, 32'h3200, 32'h0000_0014, 6'b000001, 0, 1, 32'h3100, 32'h0000_0400);
    add(13, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 32'h3200, 32'h0000_0414);
    // SR write clears EXL and IM; then faulting slot discards eret and mtc0
    add(12, 12, 32'h0000_0001, 1, 0, 0, 6'b000000, 0, 0, 32'h3200, 32'h0000_FC02);
    add(12, 14, 32'hDEAD_BEEF, 1, 32'h3303, 32'h0000_0030, 6'b111111, 1, 1, 32'h3200, 32'h0000_0001);
    add(14, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h3300, 32'h3300);
    add(12, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h3300, 32'h0000_0003);
    add(13, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h3300, 32'h0000_0030);

    // reset held across an edge, outputs checked while asserted
    @(posedge clk); #1;
    a1 = 5'd12;
    #1 check("reset_sr", dout, 32'h0000_FC01);
    check("reset_intreq", {31'b0, intreq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      a1 = vecs[i].a1; a2 = vecs[i].a2; din = vecs[i].din; we = vecs[i].we;
      pc = vecs[i].pc; causein = vecs[i].causein; hwint = vecs[i].hwint; eret = vecs[i].eret;
      @(negedge clk);
      check($sformatf("v%0d_intreq", i), {31'b0, intreq}, {31'b0, vecs[i].exp_intreq});
      check($sformatf("v%0d_epc", i), epc, vecs[i].exp_epc);
      check($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
    end

    // mid-handler reset: EXL=1, ExcCode=12; reset between edges
    @(posedge clk); #1;
    a1 = 5'd0; a2 = 5'd0; din = 32'd0; we = 1'b0; pc = 32'd0; causein = 32'd0;
    hwint = 6'd0; eret = 1'b0;
    #1 reset = 1'b0;
    a1 = 5'd12;
    #1 check("midrst_sr", dout, 32'h0000_FC01);
    a1 = 5'd13;
    #1 check("midrst_cause", dout, 32'h0);
    check("midrst_epc", epc, 32'h0000_3000);
    check("midrst_intreq", {31'b0, intreq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    // live interrupt after release proves IE came back to 1 and EXL to 0
    @(posedge clk); #1;
    hwint = 6'b100000;
    #1 check("post_rst_intreq", {31'b0, intreq}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
